pixel_event_fifo: RTL

// - Buffers expanded brush pixels {x, y, colour} between packet_generator and i2c_slave.
// - The generator emits one pixel per cycle in bursts, up to brush area x symmetry copies.
// - The I2C host drains pixels slowly, so without a buffer, pixels overwrite each other.
// - First-word-fall-through queue; optional suppression of back-to-back duplicate pixels.
// - Sticky overflow flag and a drop counter, for reporting in the status byte.

---
 rtl/pixel_event_fifo_if.sv | 23 ++
 rtl/pixel_event_fifo.sv | 106 ++++++++++
 2 files changed

// File: rtl/pixel_event_fifo_if.sv
// Pixel push/pop bus between the brush packet generator, the event FIFO and the I2C reader.
// The master side drives pushes and pops. The slave side (the FIFO) presents the head entry.
interface pixel_event_fifo_if;
  logic       wr_valid;
  logic [7:0] wr_x;
  logic [7:0] wr_y;
  logic [2:0] wr_color;
  logic       rd_pop;
  logic       rd_valid;
  logic [7:0] rd_x;
  logic [7:0] rd_y;
  logic [2:0] rd_color;

  modport master (
    output wr_valid, wr_x, wr_y, wr_color, rd_pop,
    input  rd_valid, rd_x, rd_y, rd_color
  );

  modport slave (
    input  wr_valid, wr_x, wr_y, wr_color, rd_pop,
    output rd_valid, rd_x, rd_y, rd_color
  );
endinterface

// File: rtl/pixel_event_fifo.sv
// First-word-fall-through pixel queue: a push becomes visible at the head one edge later.
// There is no backpressure. A push into a full FIFO is dropped and counted, and repeated pixels can be squashed.
module pixel_event_fifo #(
  parameter int DEPTH = 16,
  parameter bit DEDUP = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  pixel_event_fifo_if.slave        bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow,
  output logic [7:0]               drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] color;
  } pix_t;

  pix_t           mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic           last_valid;
  pix_t           last_payload;

  pix_t wr_payload;
  pix_t head;
  logic not_empty;
  logic pop_eff;
  logic dup;
  logic push_acc;
  logic push_drop;

  always_comb begin
    wr_payload = '{x: bus.wr_x, y: bus.wr_y, color: bus.wr_color};
    not_empty  = (count != '0);
    full       = (count == CW'(DEPTH));
    pop_eff    = bus.rd_pop && not_empty;
    dup        = 1'b0;
    if (DEDUP) begin
      dup = last_valid && (wr_payload == last_payload);
    end
    push_acc  = bus.wr_valid && !dup && (!full || pop_eff);
    push_drop = bus.wr_valid && !dup && full && !pop_eff;
  end

  // Head is masked to zero while empty so the consumer never sees stale storage.
  assign head         = not_empty ? mem[rd_ptr] : '0;
  assign bus.rd_valid = not_empty;
  assign bus.rd_x     = head.x;
  assign bus.rd_y     = head.y;
  assign bus.rd_color = head.color;

  always_ff @(posedge clk) begin
    if (push_acc && !clear) begin
      mem[wr_ptr] <= wr_payload;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      overflow     <= 1'b0;
      drop_cnt     <= '0;
      last_valid   <= 1'b0;
      last_payload <= '0;
    end else if (clear) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      drop_cnt   <= '0;
      last_valid <= 1'b0;
    end else begin
      if (push_acc) begin
        wr_ptr       <= wr_ptr + AW'(1);
        last_payload <= wr_payload;
        last_valid   <= 1'b1;
      end else if (pop_eff && count == CW'(1)) begin
        // Draining to empty re-arms dedup so the same pixel can be queued again.
        last_valid <= 1'b0;
      end
      if (pop_eff) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push_acc && !pop_eff) begin
        count <= count + CW'(1);
      end else if (pop_eff && !push_acc) begin
        count <= count - CW'(1);
      end
      if (push_drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) begin
          drop_cnt <= drop_cnt + 8'd1;
        end
      end
    end
  end
endmodule
